sram_fifo_param: RTL

Parametrised synchronous FIFO built on a register-array SRAM: generalised successor to the team's 12-bit/8-word buffer. Adds arbitrary (non-power-of-two) depth, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush and a registered read-data valid strobe. Sits between a producer and a consumer in one clock domain.

---
 rtl/sram_fifo_param.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sram_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sram_fifo_param
// Description : Parametrised single-clock FIFO on a register-array SRAM.
//               Supports any depth from 2 to 2**addr_width words. Provides an
//               occupancy count, almost-full/almost-empty thresholds, sticky
//               overflow/underflow flags, a synchronous flush and a registered
//               read-data strobe.
// Ports       : clk, rst_n (async, active low), clear (sync flush)
//               write/data_in      - producer side
//               read/data_out/ready - consumer side (1-cycle read latency)
//               full, empty, almost_full, almost_empty, count - status
//               overflow, underflow - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module sram_fifo_param #(
  parameter int BITS       = 12,
  parameter int word_depth = 8,
  parameter int addr_width = 3,
  parameter int AF_LEVEL   = word_depth - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  write,
  input  logic [BITS-1:0]       data_in,
  input  logic                  read,
  output logic [BITS-1:0]       data_out,
  output logic                  ready,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [addr_width-1:0] c_last_addr = addr_width'(word_depth - 1);
  localparam logic [addr_width:0]   c_depth     = (addr_width + 1)'(word_depth);
  localparam logic [addr_width:0]   c_af_level  = (addr_width + 1)'(AF_LEVEL);
  localparam logic [addr_width:0]   c_ae_level  = (addr_width + 1)'(AE_LEVEL);

  logic [BITS-1:0]       r_mem [word_depth];
  logic [addr_width-1:0] r_wr_ptr;
  logic [addr_width-1:0] r_rd_ptr;
  logic [addr_width:0]   r_count;
  logic [BITS-1:0]       r_data_out;
  logic                  r_ready;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_almost_full;
  logic                  r_almost_empty;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic [addr_width:0]   w_count_nxt;

  // Pointers wrap at the configured depth rather than at the binary limit,
  // so non-power-of-two depths use exactly word_depth storage words.
  function automatic logic [addr_width-1:0] f_ptr_inc(input logic [addr_width-1:0] ptr);
    return (ptr == c_last_addr) ? '0 : ptr + 1'b1;
  endfunction

  // A write into a full FIFO is still accepted when a read frees a slot in
  // the same cycle; a read of an empty FIFO never falls through to the write.
  assign w_rd_ok = read && !r_empty;
  assign w_wr_ok = write && (!r_full || w_rd_ok);

  always_comb begin
    w_count_nxt = r_count;
    if (clear) begin
      w_count_nxt = '0;
    end else if (w_wr_ok && !w_rd_ok) begin
      w_count_nxt = r_count + 1'b1;
    end else if (w_rd_ok && !w_wr_ok) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Storage is deliberately left out of reset and flush.
  always_ff @(posedge clk) begin
    if (!clear && w_wr_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_data_out  <= '0;
      r_ready     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_data_out  <= '0;
      r_ready     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_ready <= w_rd_ok;
      if (w_wr_ok) begin
        r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      end
      if (w_rd_ok) begin
        r_rd_ptr   <= f_ptr_inc(r_rd_ptr);
        r_data_out <= r_mem[r_rd_ptr];
      end
      if (write && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
      if (read && !w_rd_ok) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Count and every status flag are registered from the same next-state
  // count, so they can never disagree with each other in any cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == c_depth);
      r_empty        <= (w_count_nxt == '0);
      r_almost_full  <= (w_count_nxt >= c_af_level);
      r_almost_empty <= (w_count_nxt <= c_ae_level);
    end
  end

  assign data_out     = r_data_out;
  assign ready        = r_ready;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire
